// File: rtl/nibble_alu_sequencer.sv
// Multi-cycle WIDTH-bit ALU controller driving one external 4-bit slice, one nibble per cycle.
// The controller derives the inter-nibble carry/borrow from the operand nibbles itself.
module nibble_alu_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_op_a,
    input  logic [WIDTH-1:0] i_op_b,
    input  logic [2:0]       i_op_s,
    input  logic             i_op_cin,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result,
    output logic             o_carry_out,
    output logic             o_zero,
    output logic [3:0]       o_alu_a,
    output logic [3:0]       o_alu_b,
    output logic [2:0]       o_alu_s,
    output logic             o_alu_cn,
    input  logic [3:0]       i_alu_f
);

    localparam int N  = WIDTH / 4;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_s;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_result;
    logic             r_carry_out;
    logic             r_zero;

    logic [CW+1:0]    w_idx;
    logic [3:0]       w_a_nib;
    logic [3:0]       w_b_nib;
    logic             w_last;
    logic             w_carry_next;
    logic [WIDTH-1:0] w_result_next;

    assign w_idx   = {r_cnt, 2'b00};
    assign w_a_nib = r_a[w_idx +: 4];
    assign w_b_nib = r_b[w_idx +: 4];
    assign w_last  = (r_cnt == CW'(N - 1));

    // Carry/borrow out of the current nibble, from operand nibbles and the carry register
    always_comb begin
        w_carry_next = 1'b0;
        case (r_s)
            3'b011:  w_carry_next = ({1'b0, w_a_nib} + {1'b0, w_b_nib} + {4'b0000, r_carry}) > 5'd15;
            3'b010:  w_carry_next = {1'b0, w_a_nib} < ({1'b0, w_b_nib} + {4'b0000, r_carry});
            3'b001:  w_carry_next = {1'b0, w_b_nib} < ({1'b0, w_a_nib} + {4'b0000, r_carry});
            default: w_carry_next = 1'b0;
        endcase
    end

    // Result with the slice output merged into the current nibble position
    always_comb begin
        w_result_next = r_result;
        w_result_next[w_idx +: 4] = i_alu_f;
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_start) w_state_next = ST_RUN;
                else         w_state_next = ST_IDLE;
            end
            ST_RUN: begin
                if (w_last) w_state_next = ST_DONE;
                else        w_state_next = ST_RUN;
            end
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    // Operand latch, nibble stepping and result/flag capture
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_a         <= '0;
            r_b         <= '0;
            r_s         <= 3'b000;
            r_carry     <= 1'b0;
            r_cnt       <= '0;
            r_result    <= '0;
            r_carry_out <= 1'b0;
            r_zero      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_a         <= i_op_a;
                        r_b         <= i_op_b;
                        r_s         <= i_op_s;
                        r_carry     <= i_op_cin;
                        r_cnt       <= '0;
                        r_carry_out <= 1'b0;
                        r_zero      <= 1'b0;
                    end
                end
                ST_RUN: begin
                    r_result <= w_result_next;
                    r_carry  <= w_carry_next;
                    // Counter returns to zero after the last nibble so it never leaves 0..N-1
                    if (w_last) begin
                        r_cnt       <= '0;
                        r_carry_out <= w_carry_next;
                        r_zero      <= (w_result_next == '0);
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

    // Slice drive: live nibbles only in RUN, function select always reflects the latched code
    always_comb begin
        o_alu_s = r_s;
        if (r_state == ST_RUN) begin
            o_alu_a  = w_a_nib;
            o_alu_b  = w_b_nib;
            o_alu_cn = r_carry;
        end else begin
            o_alu_a  = 4'h0;
            o_alu_b  = 4'h0;
            o_alu_cn = 1'b0;
        end
    end

    assign o_busy      = (r_state == ST_RUN);
    assign o_done      = (r_state == ST_DONE);
    assign o_result    = r_result;
    assign o_carry_out = r_carry_out;
    assign o_zero      = r_zero;

endmodule

// File: tb/tb_nibble_alu_sequencer.sv
// Bench for nibble_alu_sequencer: a 4-bit slice model closes the loop, and a whole-word
// arithmetic reference model predicts results, flags and per-nibble carry-ins.
module tb_nibble_alu_sequencer;

    localparam int WIDTH = 32;
    localparam int N     = WIDTH / 4;

    logic              clk;
    logic              rst;
    logic              start;
    logic [WIDTH-1:0]  op_a;
    logic [WIDTH-1:0]  op_b;
    logic [2:0]        op_s;
    logic              op_cin;
    logic              busy;
    logic              done;
    logic [WIDTH-1:0]  result;
    logic              carry_out;
    logic              zero;
    logic [3:0]        alu_a;
    logic [3:0]        alu_b;
    logic [2:0]        alu_s;
    logic              alu_cn;
    logic [3:0]        alu_f;

    int checks;
    int failures;

    nibble_alu_sequencer #(.WIDTH(WIDTH)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_op_a      (op_a),
        .i_op_b      (op_b),
        .i_op_s      (op_s),
        .i_op_cin    (op_cin),
        .o_busy      (busy),
        .o_done      (done),
        .o_result    (result),
        .o_carry_out (carry_out),
        .o_zero      (zero),
        .o_alu_a     (alu_a),
        .o_alu_b     (alu_b),
        .o_alu_s     (alu_s),
        .o_alu_cn    (alu_cn),
        .i_alu_f     (alu_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External 4-bit slice
    function automatic logic [3:0] slice_f(input logic [3:0] a, input logic [3:0] b,
                                           input logic [2:0] s, input logic cn);
        case (s)
            3'b000:  return 4'h0;
            3'b001:  return b - a - {3'b000, cn};
            3'b010:  return a - b - {3'b000, cn};
            3'b011:  return a + b + {3'b000, cn};
            3'b100:  return a ^ b;
            3'b101:  return a | b;
            3'b110:  return a & b;
            default: return 4'hF;
        endcase
    endfunction

    assign alu_f = slice_f(alu_a, alu_b, alu_s, alu_cn);

    // Whole-word reference
    task automatic ref_model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] s,
                             input logic cin, output logic [31:0] res, output logic cout);
        logic [32:0] wide;
        cout = 1'b0;
        case (s)
            3'b000: res = 32'h0;
            3'b001: begin res = b - a - {31'd0, cin}; cout = ({1'b0, b} < ({1'b0, a} + {32'd0, cin})); end
            3'b010: begin res = a - b - {31'd0, cin}; cout = ({1'b0, a} < ({1'b0, b} + {32'd0, cin})); end
            3'b011: begin wide = {1'b0, a} + {1'b0, b} + {32'd0, cin}; res = wide[31:0]; cout = wide[32]; end
            3'b100: res = a ^ b;
            3'b101: res = a | b;
            3'b110: res = a & b;
            default: res = 32'hFFFF_FFFF;
        endcase
    endtask

    // Carry/borrow into nibble k = carry/borrow out of the low 4k bits of the word operation
    function automatic logic low_carry(input logic [31:0] a, input logic [31:0] b,
                                       input logic [2:0] s, input logic cin, input int k);
        logic [63:0] m;
        logic [63:0] la;
        logic [63:0] lb;
        logic [63:0] c;
        m  = (64'd1 << (4 * k)) - 64'd1;
        la = {32'd0, a} & m;
        lb = {32'd0, b} & m;
        c  = {63'd0, cin};
        case (s)
            3'b011:  return (la + lb + c) >= (64'd1 << (4 * k));
            3'b010:  return la < (lb + c);
            3'b001:  return lb < (la + c);
            default: return (k == 0) ? cin : 1'b0;
        endcase
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] s,
                          input logic cin, input int restart_at);
        logic [31:0] exp_res;
        logic        exp_c;
        logic [11:0] exp_drive;
        ref_model(a, b, s, cin, exp_res, exp_c);
        @(negedge clk);
        op_a = a; op_b = b; op_s = s; op_cin = cin; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        op_a = $urandom; op_b = $urandom; op_s = 3'($urandom_range(0, 7)); op_cin = 1'($urandom_range(0, 1));
        for (int k = 0; k < N; k++) begin
            checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                failures++;
                $display("FAIL run_status k=%0d busy=%b done=%b required busy=1 done=0", k, busy, done);
            end
            exp_drive = {a[4*k +: 4], b[4*k +: 4], s, low_carry(a, b, s, cin, k)};
            checks++;
            if ({alu_a, alu_b, alu_s, alu_cn} !== exp_drive) begin
                failures++;
                $display("FAIL slice_drive k=%0d a/b/s/cn=%h/%h/%b/%b required %h/%h/%b/%b",
                         k, alu_a, alu_b, alu_s, alu_cn, exp_drive[11:8], exp_drive[7:4], exp_drive[3:1], exp_drive[0]);
            end
            if (k == restart_at) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL done_timing done=%b busy=%b required done=1 busy=0", done, busy);
        end
        checks++;
        if (result !== exp_res) begin
            failures++;
            $display("FAIL result s=%b a=%h b=%h cin=%b got=%h required=%h", s, a, b, cin, result, exp_res);
        end
        checks++;
        if (carry_out !== exp_c || zero !== (exp_res == 32'h0)) begin
            failures++;
            $display("FAIL flags s=%b carry_out=%b zero=%b required %b %b", s, carry_out, zero, exp_c, exp_res == 32'h0);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || result !== exp_res || carry_out !== exp_c) begin
            failures++;
            $display("FAIL hold done=%b busy=%b result=%h cout=%b required 0 0 %h %b", done, busy, result, carry_out, exp_res, exp_c);
        end
        checks++;
        if ({alu_a, alu_b, alu_s, alu_cn} !== {4'h0, 4'h0, s, 1'b0}) begin
            failures++;
            $display("FAIL idle_drive a/b/s/cn=%h/%h/%b/%b required 0/0/%b/0", alu_a, alu_b, alu_s, alu_cn, s);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0; op_s = 3'b000; op_cin = 1'b0;
        #12;
        checks++;
        if ({busy, done, result, carry_out, zero, alu_a, alu_b, alu_s, alu_cn} !== 47'd0) begin
            failures++;
            $display("FAIL reset_state busy=%b done=%b result=%h cout=%b zero=%b alu=%h/%h/%b/%b required all 0",
                     busy, done, result, carry_out, zero, alu_a, alu_b, alu_s, alu_cn);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_add_carry();
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 3'b011, 1'b0, -1);
    endtask

    task automatic test_subtract();
        run_op(32'h0000_0005, 32'h0000_0007, 3'b010, 1'b0, -1);
        run_op(32'h0000_0003, 32'h0000_0010, 3'b001, 1'b0, -1);
    endtask

    task automatic test_logic();
        run_op(32'hF0F0_F0F0, 32'hFF00_FF00, 3'b100, 1'b0, -1);
        run_op(32'hF0F0_F0F0, 32'hFF00_FF00, 3'b111, 1'b1, -1);
        run_op(32'hF0F0_F0F0, 32'hFF00_FF00, 3'b000, 1'b1, -1);
        run_op(32'h1234_5678, 32'h0F0F_0F0F, 3'b101, 1'b0, -1);
        run_op(32'h1234_5678, 32'h0F0F_0F0F, 3'b110, 1'b1, -1);
    endtask

    task automatic test_start_ignored();
        run_op(32'h0000_1234, 32'h0000_4321, 3'b011, 1'b1, 2);
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        op_a = 32'hDEAD_BEEF; op_b = 32'h0BAD_F00D; op_s = 3'b011; op_cin = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, result, carry_out, zero, alu_a, alu_b, alu_s, alu_cn} !== 47'd0) begin
            failures++;
            $display("FAIL async_reset busy=%b done=%b result=%h cout=%b zero=%b alu=%h/%h/%b/%b required all 0",
                     busy, done, result, carry_out, zero, alu_a, alu_b, alu_s, alu_cn);
        end
        @(negedge clk);
        rst = 1'b0;
        run_op(32'h1234_5678, 32'h1111_1111, 3'b011, 1'b0, -1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            run_op($urandom, $urandom, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), -1);
        end
        run_op(32'h0000_0000, 32'h0000_0000, 3'b010, 1'b1, -1);
        run_op(32'h8000_0000, 32'h8000_0000, 3'b011, 1'b1, -1);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_add_carry();
        test_subtract();
        test_logic();
        test_start_ignored();
        test_reset_mid_run();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
